// File: rtl/bitwise_logic_explorer.sv
// bitwise_logic_explorer
//   Logic-operation lab block. A selectable bitwise operation is applied to
//   two operands and registered onto `result`. A sweep engine enumerates
//   every operand pair and counts violations of three identities: XOR
//   composed from AND/OR/NOT, and both De Morgan laws.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   a, b          : operands (used directly, no synchroniser)
//   key_mode      : raw key, each debounced press steps `op`
//   key_sweep     : raw key, each debounced press starts a sweep
//   fault_inject  : level, inverts bit 0 of the composed-XOR path
//   op            : current operation code
//   result        : registered result of `op` applied to a, b
//   busy          : high while sweeping
//   done          : sticky sweep-complete flag
//   pass          : done and no mismatches
//   error_count   : mismatches found by the last or current sweep
module bitwise_logic_explorer #(
  parameter int width           = 4,
  parameter int debounce_cycles = 50000,
  parameter int w_cnt           = 2*width+2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             key_mode,
  input  logic             key_sweep,
  input  logic             fault_inject,
  output logic [2:0]       op,
  output logic [width-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [w_cnt-1:0] error_count
);

  localparam int DB_W  = $clog2(debounce_cycles + 1);
  localparam int IDX_W = 2 * width;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(debounce_cycles - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [width-1:0] composed_xor(
    input logic [width-1:0] x,
    input logic [width-1:0] y,
    input logic             f
  );
    logic [width-1:0] r;
    r    = (~x & y) | (x & ~y);
    r[0] = r[0] ^ f;
    return r;
  endfunction

  // All ones when both De Morgan laws hold bitwise.
  function automatic logic [width-1:0] demorgan_vec(
    input logic [width-1:0] x,
    input logic [width-1:0] y
  );
    return ~((~(x & y)) ^ (~x | ~y)) & ~((~(x | y)) ^ (~x & ~y));
  endfunction

  function automatic logic [width-1:0] op_eval(
    input logic [2:0]       o,
    input logic [width-1:0] x,
    input logic [width-1:0] y,
    input logic             f
  );
    logic [width-1:0] r;
    case (o)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = x ^ y;
      3'd3:    r = ~(x & y);
      3'd4:    r = ~(x | y);
      3'd5:    r = ~(x ^ y);
      3'd6:    r = composed_xor(x, y, f);
      default: r = demorgan_vec(x, y);
    endcase
    return r;
  endfunction

  // Key index 0 = mode, 1 = sweep.
  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;
  logic [1:0]      deb_q, deb_d;
  logic [1:0]      pulse_q, pulse_d;
  logic [DB_W-1:0] cnt_q [2];
  logic [DB_W-1:0] cnt_d [2];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [w_cnt-1:0] err_q, err_d;
  logic [2:0]       op_q, op_d;
  logic [width-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [width-1:0] sa, sb;
  logic [2:0]       chk_fail;
  logic [w_cnt-1:0] err_inc;

  // Debounce: the level follows the synchronised key only after it has
  // disagreed for debounce_cycles consecutive cycles; agreement clears the count.
  always_comb begin
    sync1_d = {key_sweep, key_mode};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    pulse_d = 2'b00;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == DB_LAST) begin
          deb_d[k]   = sync2_q[k];
          pulse_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    sa       = idx_q[IDX_W-1:width];
    sb       = idx_q[width-1:0];
    chk_fail = {(~(sa | sb)) != (~sa & ~sb),
                (~(sa & sb)) != (~sa | ~sb),
                composed_xor(sa, sb, fault_inject) != (sa ^ sb)};
    err_inc  = w_cnt'(chk_fail[0]) + w_cnt'(chk_fail[1]) + w_cnt'(chk_fail[2]);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    case (state_q)
      ST_SWEEP: begin
        // Sweep pulses are ignored here.
        err_d = err_q + err_inc;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) state_d = ST_DONE;
      end
      ST_IDLE, ST_DONE: begin
        if (pulse_q[1]) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
          err_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d   = (state_d == ST_SWEEP);
    done_d   = (state_d == ST_DONE);
    pass_d   = done_d && (err_d == '0);
    op_d     = op_q + {2'b00, pulse_q[0]};
    result_d = op_eval(op_q, a, b, fault_inject);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      pulse_q  <= '0;
      for (int k = 0; k < 2; k++) cnt_q[k] <= '0;
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      err_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      pulse_q  <= pulse_d;
      for (int k = 0; k < 2; k++) cnt_q[k] <= cnt_d[k];
      state_q  <= state_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      op_q     <= op_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign op          = op_q;
  assign result      = result_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign error_count = err_q;

endmodule

// File: tb/tb_bitwise_logic_explorer.sv
// tb_bitwise_logic_explorer
//   Directed bench. u_dut4 (width 4) covers operations and debounce;
//   u_dut2 (width 2) covers sweeps. Both use debounce_cycles = 4.
module tb_bitwise_logic_explorer;

  logic clk = 1'b0;
  logic rst;

  logic [3:0] a4, b4, res4;
  logic       km4, ks4, fi4, busy4, done4, pass4;
  logic [2:0] op4;
  logic [9:0] err4;

  logic [1:0] a2, b2, res2;
  logic       km2, ks2, fi2, busy2, done2, pass2;
  logic [2:0] op2;
  logic [5:0] err2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bitwise_logic_explorer #(.width(4), .debounce_cycles(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .key_mode(km4), .key_sweep(ks4),
    .fault_inject(fi4), .op(op4), .result(res4), .busy(busy4), .done(done4),
    .pass(pass4), .error_count(err4)
  );

  bitwise_logic_explorer #(.width(2), .debounce_cycles(4)) u_dut2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .key_mode(km2), .key_sweep(ks2),
    .fault_inject(fi2), .op(op2), .result(res2), .busy(busy2), .done(done2),
    .pass(pass2), .error_count(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press_mode4(input int hold);
    km4 = 1'b1;
    ticks(hold);
    km4 = 1'b0;
    ticks(12);
  endtask

  // Press sweep key on u_dut2 and return in the first busy cycle, key released.
  task automatic start_sweep2();
    ks2 = 1'b1;
    for (int t = 0; t < 40 && busy2 !== 1'b1; t++) tick();
    ks2 = 1'b0;
    checks++;
    if (busy2 !== 1'b1) begin
      errors++;
      $display("FAIL sweep_start busy=%b expected 1", busy2);
    end
  endtask

  // Count busy cycles from the current (first) busy cycle until busy drops.
  // With regrab set, re-press sweep mid-sweep so the pulse lands while busy.
  task automatic count_busy2(input bit regrab, output int n);
    int both;
    n    = 1;
    both = 0;
    while (busy2 === 1'b1 && n < 100) begin
      if (regrab && n == 7) ks2 = 1'b1;
      tick();
      if (busy2 === 1'b1) n++;
      if (busy2 === 1'b1 && done2 === 1'b1) both++;
    end
    ks2 = 1'b0;
    checks++;
    if (both != 0) begin
      errors++;
      $display("FAIL busy_done_overlap cycles=%0d expected 0", both);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    km4 = 1'b1; ks4 = 1'b1; km2 = 1'b1; ks2 = 1'b1;
    tick();
    km4 = 1'b0; ks4 = 1'b0; km2 = 1'b0; ks2 = 1'b0;
    tick();
    checks++;
    if (op4 !== 3'd0 || res4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_op_result op=%0d result=%b expected 0/0000", op4, res4);
    end
    checks++;
    if ({busy4, done4, pass4} !== 3'b000 || err4 !== 10'd0) begin
      errors++;
      $display("FAIL reset_status4 busy/done/pass=%b err=%0d expected 000/0", {busy4, done4, pass4}, err4);
    end
    checks++;
    if ({busy2, done2, pass2} !== 3'b000 || err2 !== 6'd0 || op2 !== 3'd0) begin
      errors++;
      $display("FAIL reset_status2 busy/done/pass=%b err=%0d op=%0d expected 000/0/0", {busy2, done2, pass2}, err2, op2);
    end
    rst = 1'b0;
    ticks(15);
    checks++;
    if (op4 !== 3'd0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_step op=%0d busy=%b expected 0/0", op4, busy2);
    end
  endtask

  task automatic test_ops();
    logic [3:0] exp_r [8];
    exp_r = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0110, 4'b1111};
    a4 = 4'b1100;
    b4 = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      ticks(2);
      checks++;
      if (op4 !== 3'(i)) begin
        errors++;
        $display("FAIL op_value op=%0d expected %0d", op4, i);
      end
      checks++;
      if (res4 !== exp_r[i]) begin
        errors++;
        $display("FAIL op_result op=%0d result=%b expected %b", i, res4, exp_r[i]);
      end
      if (i == 6) begin
        fi4 = 1'b1;
        ticks(2);
        checks++;
        if (res4 !== 4'b0111) begin
          errors++;
          $display("FAIL op6_fault result=%b expected 0111", res4);
        end
        fi4 = 1'b0;
        ticks(2);
      end
      press_mode4(10);
    end
    checks++;
    if (op4 !== 3'd0) begin
      errors++;
      $display("FAIL op_wrap op=%0d expected 0", op4);
    end
  endtask

  task automatic test_debounce();
    km4 = 1'b1;
    ticks(3);
    km4 = 1'b0;
    ticks(12);
    checks++;
    if (op4 !== 3'd0) begin
      errors++;
      $display("FAIL debounce_glitch op=%0d expected 0", op4);
    end
    // Held key: op still old after 2+4 cycles, steps on the next one.
    km4 = 1'b1;
    ticks(6);
    checks++;
    if (op4 !== 3'd0) begin
      errors++;
      $display("FAIL debounce_early op=%0d expected 0", op4);
    end
    tick();
    checks++;
    if (op4 !== 3'd1) begin
      errors++;
      $display("FAIL debounce_latency op=%0d expected 1", op4);
    end
    ticks(93);
    km4 = 1'b0;
    ticks(12);
    checks++;
    if (op4 !== 3'd1) begin
      errors++;
      $display("FAIL debounce_long_hold op=%0d expected 1", op4);
    end
    for (int i = 0; i < 6; i++) press_mode4(8);
    checks++;
    if (op4 !== 3'd7) begin
      errors++;
      $display("FAIL debounce_to7 op=%0d expected 7", op4);
    end
    press_mode4(8);
    checks++;
    if (op4 !== 3'd0) begin
      errors++;
      $display("FAIL debounce_wrap op=%0d expected 0", op4);
    end
  endtask

  task automatic test_sweep_clean();
    int n;
    fi2 = 1'b0;
    start_sweep2();
    count_busy2(1'b1, n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL clean_busy_len cycles=%0d expected 16", n);
    end
    checks++;
    if (done2 !== 1'b1 || err2 !== 6'd0 || pass2 !== 1'b1) begin
      errors++;
      $display("FAIL clean_result done=%b err=%0d pass=%b expected 1/0/1", done2, err2, pass2);
    end
    ticks(15);
    checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL clean_sticky done=%b busy=%b expected 1/0", done2, busy2);
    end
  endtask

  task automatic test_sweep_fault();
    int n;
    fi2 = 1'b1;
    start_sweep2();
    checks++;
    if (done2 !== 1'b0) begin
      errors++;
      $display("FAIL fault_done_clear done=%b expected 0", done2);
    end
    count_busy2(1'b0, n);
    checks++;
    if (done2 !== 1'b1 || err2 !== 6'd16 || pass2 !== 1'b0) begin
      errors++;
      $display("FAIL fault_result done=%b err=%0d pass=%b expected 1/16/0", done2, err2, pass2);
    end
    fi2 = 1'b0;
    ticks(10);
    start_sweep2();
    checks++;
    if (err2 !== 6'd0) begin
      errors++;
      $display("FAIL resweep_clear err=%0d expected 0", err2);
    end
    count_busy2(1'b0, n);
    checks++;
    if (n != 16 || err2 !== 6'd0 || pass2 !== 1'b1) begin
      errors++;
      $display("FAIL resweep_result cycles=%0d err=%0d pass=%b expected 16/0/1", n, err2, pass2);
    end
    ticks(10);
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    fi2 = 1'b1;
    start_sweep2();
    ticks(6);
    checks++;
    if (busy2 !== 1'b1 || err2 !== 6'd6) begin
      errors++;
      $display("FAIL mid_progress busy=%b err=%0d expected 1/6", busy2, err2);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (busy2 !== 1'b0 || err2 !== 6'd0 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset busy=%b err=%0d done=%b expected 0/0/0", busy2, err2, done2);
    end
    rst = 1'b0;
    fi2 = 1'b0;
    ticks(3);
    start_sweep2();
    count_busy2(1'b0, n);
    checks++;
    if (n != 16 || done2 !== 1'b1 || pass2 !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_sweep cycles=%0d done=%b pass=%b expected 16/1/1", n, done2, pass2);
    end
  endtask

  initial begin
    a4 = '0; b4 = '0; km4 = 1'b0; ks4 = 1'b0; fi4 = 1'b0;
    a2 = '0; b2 = '0; km2 = 1'b0; ks2 = 1'b0; fi2 = 1'b0;
    rst = 1'b1;
    test_reset();
    test_ops();
    test_debounce();
    test_sweep_clean();
    test_sweep_fault();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
